ttt_ps2_keys: RTL and testbench
===============================

// Module: ttt_ps2_keys
// PURPOSE
//  PS/2 keyboard front-end for the tic-tac-toe game; produces the up/down/left/right/enter/space
//  key levels that the game controller consumes. Receives device-to-host PS/2 frames, decodes
//  scan-code set 2 make/break sequences (incl. E0 extended prefix), and holds one level per key.
//  Sits between the board PS/2 pins and the game controller, in the same clk domain.
// PARAMETERS
//  FILTER_LEN      8      cycles ps2_clk_sync must hold a new level before the filtered clock follows it
//  TIMEOUT_CYCLES  50000  idle cycles (no filtered falling edge) mid-frame before frame abort (2 ms @25 MHz)
// PORTS
//  clk         in   1  system clock
//  reset_n     in   1  asynchronous, active-low reset
//  ps2_clk     in   1  raw PS/2 clock pin (async)
//  ps2_data    in   1  raw PS/2 data pin (async)
//  up/down/left/right/enter/space  out  1 each  key level: 1 while key held (make seen, break not yet seen)
//  scan_code   out  8  last accepted frame byte
//  scan_valid  out  1  1-cycle pulse when scan_code updates
//  frame_err   out  1  1-cycle pulse on a discarded frame (bad stop, parity if enabled, timeout)
// BEHAVIOUR
//  - Reset (async, reset_n=0): all outputs 0, both FSMs idle, ext/brk flags 0, filtered clock = 1,
//    sync flops = 1. Reset mid-frame discards the partial frame; no scan_valid follows.
//  - Input: ps2_clk, ps2_data each through 2-flop synchroniser. Filter counter: filtered clock changes only
//    after ps2_clk_sync differs from it for FILTER_LEN consecutive cycles. Data sampled on filtered falling edge.
//  - Frame FSM, one bit per falling edge: IDLE -> DATA (start bit must be 0; start=1 ignored, stay IDLE)
//    -> DATA x8, LSB first -> PARITY -> STOP -> IDLE.
//    STOP: stop bit 1 (and parity ok if checked) -> scan_code <= byte, scan_valid=1 next cycle;
//    otherwise frame_err=1, byte discarded.
//  - Timeout: in DATA/PARITY/STOP, counter counts cycles since last falling edge; reaching TIMEOUT_CYCLES
//    -> IDLE, frame_err pulse, counter cleared. Counter held at 0 in IDLE.
//  - Decoder, acts on each accepted byte (same cycle as scan_valid pulse, key outputs update 1 cycle later):
//    E0 -> ext<=1; F0 -> brk<=1; other byte -> lookup (ext,byte), selected key <= ~brk, then ext,brk <= 0.
//    Map: E0 75 up, E0 72 down, E0 6B left, E0 74 right, 5A enter (also E0 5A keypad enter), 29 space.
//    Unmapped byte (incl. AA, FA, FE, E1): no key change, ext/brk cleared.
//  - Keys independent: several may be 1 at once; repeated make (typematic) keeps level 1, no glitch.
//  - Frame error or timeout does NOT clear ext/brk (next valid byte completes the sequence).
//  - Latency: last (stop) falling edge -> scan_valid 1 cycle -> key level 1 cycle later.
// CONFIGURATION
//  TTT_PS2_PARITY_CHECK_EN defined: odd parity over 8 data + parity bit checked in STOP; mismatch -> frame_err,
//    byte discarded, decoder flags untouched.
//  Not defined: parity bit sampled and ignored; only stop bit and timeout produce frame_err.
// TESTING
//  - Frames E0,75 (valid parity/stop) -> scan_valid x2, scan_code=75, up=1; others 0.
//  - Then E0,F0,75 -> up=0; ext/brk back to 0; scan_code=75.
//  - 5A then 29 without breaks -> enter=1 and space=1 simultaneously; F0,5A -> enter=0, space stays 1.
//  - 75 without E0 -> no key change (keypad 8), scan_valid pulse, scan_code=75.
//  - Frame with stop=0 -> frame_err pulse, no scan_valid; with TTT_PS2_PARITY_CHECK_EN, wrong parity on 29
//    -> frame_err, space stays 0; without macro same frame -> space=1.
//  - Stop ps2_clk after 4 data bits for TIMEOUT_CYCLES -> frame_err pulse, FSM IDLE; next full frame 5A
//    -> enter=1. Assert reset_n=0 mid-frame -> all outputs 0 immediately, next frame decodes normally.
//  - Glitch: ps2_clk low for FILTER_LEN-1 cycles -> no bit sampled, no state change.

Source files
------------

// File: rtl/ttt_ps2_keys.sv
// PS/2 keyboard front-end for tic-tac-toe: synchronise, de-glitch and deframe the PS/2 stream,
// then decode scan-code set 2 make/break sequences into held key levels.
// Optional odd-parity check in the STOP state is enabled by defining TTT_PS2_PARITY_CHECK_EN.
module ttt_ps2_keys #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       up,
  output logic       down,
  output logic       left,
  output logic       right,
  output logic       enter,
  output logic       space,
  output logic [7:0] scan_code,
  output logic       scan_valid,
  output logic       frame_err
);

`ifdef TTT_PS2_PARITY_CHECK_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  localparam int FCW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int TCW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam int K_UP    = 5;
  localparam int K_DOWN  = 4;
  localparam int K_LEFT  = 3;
  localparam int K_RIGHT = 2;
  localparam int K_ENTER = 1;
  localparam int K_SPACE = 0;

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} frame_state_e;

  logic           clk_meta_q, clk_sync_q, data_meta_q, data_sync_q;
  logic           filt_q, filt_d;
  logic [FCW-1:0] filt_cnt_q, filt_cnt_d;
  logic           fall;

  frame_state_e   state_q, state_d;
  logic [2:0]     bit_cnt_q, bit_cnt_d;
  logic [7:0]     shift_q, shift_d;
  logic           par_q, par_d;
  logic [TCW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [7:0]     scan_code_q, scan_code_d;
  logic           scan_valid_q, scan_valid_d;
  logic           frame_err_q, frame_err_d;
  logic           frame_ok;

  logic [5:0]     key_q, key_d;
  logic           ext_q, ext_d, brk_q, brk_d;

  // NOTE: sync flops and the filtered clock reset to 1, the idle line level, so reset release
  // can never look like a falling edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_meta_q  <= 1'b1;
      clk_sync_q  <= 1'b1;
      data_meta_q <= 1'b1;
      data_sync_q <= 1'b1;
      filt_q      <= 1'b1;
      filt_cnt_q  <= '0;
    end else begin
      clk_meta_q  <= ps2_clk;
      clk_sync_q  <= clk_meta_q;
      data_meta_q <= ps2_data;
      data_sync_q <= data_meta_q;
      filt_q      <= filt_d;
      filt_cnt_q  <= filt_cnt_d;
    end
  end

  // NOTE: every signal driven here gets its default first, so no path can infer a latch.
  always_comb begin
    filt_d     = filt_q;
    filt_cnt_d = '0;
    if (clk_sync_q != filt_q) begin
      if (filt_cnt_q == FCW'(FILTER_LEN - 1)) filt_d = clk_sync_q;
      else                                     filt_cnt_d = filt_cnt_q + FCW'(1);
    end
  end

  assign fall     = filt_q & ~filt_d;
  assign frame_ok = data_sync_q & (~PARITY_EN | (^{shift_q, par_q}));

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    par_d        = par_q;
    tmo_cnt_d    = tmo_cnt_q;
    scan_code_d  = scan_code_q;
    scan_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    if (state_q == S_IDLE) begin
      tmo_cnt_d = '0;
      if (fall && !data_sync_q) begin
        state_d   = S_DATA;
        bit_cnt_d = '0;
      end
    end else if (fall) begin
      tmo_cnt_d = '0;
      case (state_q)
        S_DATA: begin
          shift_d   = {data_sync_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = S_PARITY;
        end
        S_PARITY: begin
          par_d   = data_sync_q;
          state_d = S_STOP;
        end
        S_STOP: begin
          state_d = S_IDLE;
          if (frame_ok) begin
            scan_code_d  = shift_q;
            scan_valid_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end else if (tmo_cnt_q == TCW'(TIMEOUT_CYCLES - 1)) begin
      // Line went quiet mid-frame: drop the partial byte.
      state_d     = S_IDLE;
      tmo_cnt_d   = '0;
      frame_err_d = 1'b1;
    end else begin
      tmo_cnt_d = tmo_cnt_q + TCW'(1);
    end
  end

  // Decoder acts on the accepted byte while scan_valid is high; key levels follow one cycle later.
  always_comb begin
    key_d = key_q;
    ext_d = ext_q;
    brk_d = brk_q;
    if (scan_valid_q) begin
      if (scan_code_q == 8'hE0) begin
        ext_d = 1'b1;
      end else if (scan_code_q == 8'hF0) begin
        brk_d = 1'b1;
      end else begin
        ext_d = 1'b0;
        brk_d = 1'b0;
        case ({ext_q, scan_code_q})
          9'h175:         key_d[K_UP]    = ~brk_q;
          9'h172:         key_d[K_DOWN]  = ~brk_q;
          9'h16B:         key_d[K_LEFT]  = ~brk_q;
          9'h174:         key_d[K_RIGHT] = ~brk_q;
          9'h05A, 9'h15A: key_d[K_ENTER] = ~brk_q;
          9'h029:         key_d[K_SPACE] = ~brk_q;
          default:        ;
        endcase
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      par_q        <= 1'b0;
      tmo_cnt_q    <= '0;
      scan_code_q  <= '0;
      scan_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      key_q        <= '0;
      ext_q        <= 1'b0;
      brk_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      par_q        <= par_d;
      tmo_cnt_q    <= tmo_cnt_d;
      scan_code_q  <= scan_code_d;
      scan_valid_q <= scan_valid_d;
      frame_err_q  <= frame_err_d;
      key_q        <= key_d;
      ext_q        <= ext_d;
      brk_q        <= brk_d;
    end
  end

  assign up         = key_q[K_UP];
  assign down       = key_q[K_DOWN];
  assign left       = key_q[K_LEFT];
  assign right      = key_q[K_RIGHT];
  assign enter      = key_q[K_ENTER];
  assign space      = key_q[K_SPACE];
  assign scan_code  = scan_code_q;
  assign scan_valid = scan_valid_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_ttt_ps2_keys.sv
// Self-checking bench for ttt_ps2_keys: directed scenarios plus random byte streams,
// checked against a key-level model built from the scan-code make/break rules.
module tb_ttt_ps2_keys;
  localparam int FILTER_LEN     = 8;
  localparam int TIMEOUT_CYCLES = 600;
  localparam int HALF           = 20;

`ifdef TTT_PS2_PARITY_CHECK_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       up, down, left, right, enter, space;
  logic [7:0] scan_code;
  logic       scan_valid, frame_err;
  logic [5:0] dut_keys;

  int checks = 0, errors = 0;
  int sv_total = 0, fe_total = 0, exp_sv = 0, exp_fe = 0;

  // Reference model state: key levels {up,down,left,right,enter,space}, prefix flags, last byte.
  logic [5:0] m_keys = '0;
  bit         m_ext = 0, m_brk = 0;
  logic [7:0] m_code = '0;

  ttt_ps2_keys #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
    .clk(clk), .reset_n(reset_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .up(up), .down(down), .left(left), .right(right), .enter(enter), .space(space),
    .scan_code(scan_code), .scan_valid(scan_valid), .frame_err(frame_err)
  );

  assign dut_keys = {up, down, left, right, enter, space};

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (scan_valid === 1'b1) sv_total++;
    if (frame_err === 1'b1)  fe_total++;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Key slot for a completed (ext, byte) pair, -1 when unmapped.
  function automatic int key_slot(bit ext, logic [7:0] b);
    if (b == 8'h5A)         return 1;
    if (!ext && b == 8'h29) return 0;
    if (ext) begin
      if (b == 8'h75) return 5;
      if (b == 8'h72) return 4;
      if (b == 8'h6B) return 3;
      if (b == 8'h74) return 2;
    end
    return -1;
  endfunction

  task automatic model_byte(input logic [7:0] b);
    int k;
    m_code = b;
    if (b == 8'hE0)      m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else begin
      k = key_slot(m_ext, b);
      if (k >= 0) m_keys[k] = !m_brk;
      m_ext = 0;
      m_brk = 0;
    end
  endtask

  task automatic drive_bit(input bit v);
    @(negedge clk) ps2_data = v;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_partial(input int nbits);
    drive_bit(1'b0);
    for (int i = 0; i < nbits; i++) drive_bit(1'($urandom_range(0, 1)));
  endtask

  task automatic send_frame(input string tag, input logic [7:0] b, input bit bad_stop, input bit bad_par);
    logic par;
    bit   good, seen_v, seen_e;
    int   waited;
    par  = (~^b) ^ bad_par;
    good = !bad_stop && !(PAR_EN && bad_par);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(par);
    @(negedge clk) ps2_data = ~bad_stop;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    seen_v = 0;
    seen_e = 0;
    waited = 0;
    while (!seen_v && !seen_e && waited < 2 * HALF) begin
      @(negedge clk);
      waited++;
      seen_v = scan_valid;
      seen_e = frame_err;
    end
    if (good) begin
      check({tag, "/valid"}, 32'(seen_v), 1);
      check({tag, "/err"}, 32'(seen_e), 0);
      check({tag, "/code"}, scan_code, b);
      check({tag, "/keys_before"}, dut_keys, m_keys);
      model_byte(b);
      exp_sv++;
      @(negedge clk);
      check({tag, "/pulse_len"}, scan_valid, 0);
      check({tag, "/keys"}, dut_keys, m_keys);
    end else begin
      check({tag, "/valid"}, 32'(seen_v), 0);
      check({tag, "/err"}, 32'(seen_e), 1);
      exp_fe++;
      @(negedge clk);
      check({tag, "/code_held"}, scan_code, m_code);
      check({tag, "/keys"}, dut_keys, m_keys);
    end
    repeat (HALF) @(negedge clk);
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "/keys"}, dut_keys, 0);
    check({tag, "/code"}, scan_code, 0);
    check({tag, "/pulses"}, {scan_valid, frame_err}, 0);
  endtask

  initial begin
    logic [7:0] pool [13];
    logic [7:0] b;
    int         snap_sv, snap_fe, waited;
    bit         seen_e, seen_v;
    pool = '{8'hE0, 8'hF0, 8'h75, 8'h72, 8'h6B, 8'h74, 8'h5A, 8'h29,
             8'hAA, 8'hFA, 8'hFE, 8'hE1, 8'h00};

    repeat (4) @(negedge clk);
    check_all_zero("reset");
    reset_n = 1'b1;
    repeat (10) @(negedge clk);

    send_frame("up_e0", 8'hE0, 0, 0);
    send_frame("up_make", 8'h75, 0, 0);
    check("up_level", up, 1);
    send_frame("up_brk_e0", 8'hE0, 0, 0);
    send_frame("up_brk_f0", 8'hF0, 0, 0);
    send_frame("up_brk", 8'h75, 0, 0);
    check("up_released", up, 0);

    send_frame("enter_make", 8'h5A, 0, 0);
    send_frame("space_make", 8'h29, 0, 0);
    check("enter_space", {enter, space}, 2'b11);
    send_frame("enter_rep", 8'h5A, 0, 0);
    send_frame("enter_brk_f0", 8'hF0, 0, 0);
    send_frame("enter_brk", 8'h5A, 0, 0);
    check("space_held", {enter, space}, 2'b01);

    send_frame("keypad8", 8'h75, 0, 0);
    send_frame("space_brk_f0", 8'hF0, 0, 0);
    send_frame("space_brk", 8'h29, 0, 0);

    send_frame("bad_stop", 8'h5A, 1, 0);
    send_frame("bad_parity", 8'h29, 0, 1);
    check("parity_space", space, PAR_EN ? 0 : 1);
    send_frame("cleanup_f0", 8'hF0, 0, 0);
    send_frame("cleanup", 8'h29, 0, 0);

    // Prefix survives a discarded frame.
    send_frame("keep_e0", 8'hE0, 0, 0);
    send_frame("keep_err", 8'h33, 1, 0);
    send_frame("keep_make", 8'h72, 0, 0);
    check("down_level", down, 1);

    // Glitch shorter than the filter must not start a frame.
    snap_sv = sv_total;
    snap_fe = fe_total;
    @(negedge clk) ps2_data = 1'b0;
    repeat (2) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (FILTER_LEN - 1) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (4) @(negedge clk);
    ps2_data = 1'b1;
    repeat (30) @(negedge clk);
    check("glitch_pulses", sv_total - snap_sv + fe_total - snap_fe, 0);
    send_frame("after_glitch", 8'h29, 0, 0);

    // Stalled frame times out.
    send_partial(4);
    seen_e = 0;
    seen_v = 0;
    waited = 0;
    while (!seen_e && waited < TIMEOUT_CYCLES + 200) begin
      @(negedge clk);
      waited++;
      seen_e = frame_err;
      if (scan_valid) seen_v = 1;
    end
    check("timeout_err", 32'(seen_e), 1);
    check("timeout_valid", 32'(seen_v), 0);
    exp_fe++;
    send_frame("after_timeout", 8'h5A, 0, 0);
    check("enter_after_timeout", enter, 1);

    // Reset in the middle of a frame.
    send_partial(4);
    @(negedge clk) reset_n = 1'b0;
    #1;
    check_all_zero("mid_reset");
    m_keys = '0;
    m_ext  = 0;
    m_brk  = 0;
    m_code = '0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    send_frame("after_reset", 8'h29, 0, 0);
    check("after_reset_keys", dut_keys, 6'b000001);

    for (int n = 0; n < 40; n++) begin
      int r;
      r = $urandom_range(0, 12);
      b = (r == 12) ? 8'($urandom) : pool[r];
      send_frame($sformatf("rnd%0d", n), b, $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0);
    end

    repeat (20) @(negedge clk);
    check("total_scan_valid", sv_total, exp_sv);
    check("total_frame_err", fe_total, exp_fe);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
